// File: rtl/switch_toggle_bank.sv
// switch_toggle_bank: a bank of independent push-switch channels. Each channel
// synchronises, debounces and classifies its switch and drives a toggling LED.
module switch_toggle_bank #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int EDGE_MODE       = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Toggle,
  output logic [NUM_CH-1:0] o_Hold
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    RELEASED,
    PRESSED,
    HELD
  } state_t;

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic              db_q, db_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              led_q, led_d;
    logic              tog_q, tog_d;
    logic              hold_q, hold_d;

    // A differing level must persist for a full run; any revert restarts it.
    always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      if (sync2_q[n] != db_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_d = sync2_q[n];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        RELEASED: if (db_q) state_d = PRESSED;
        PRESSED: begin
          if (!db_q) begin
            state_d = RELEASED;
          end else if ((HOLD_CYCLES != 0) && (hold_cnt_q == HOLD_LAST)) begin
            state_d = HELD;
          end
        end
        HELD:     if (!db_q) state_d = RELEASED;
        default:  state_d = RELEASED;
      endcase
    end

    always_comb begin
      hold_cnt_d = '0;
      if ((HOLD_CYCLES != 0) && (state_q == PRESSED) && (state_d == PRESSED)) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end

    // Clear and hold entry both force the LED low; the pulses are unaffected.
    always_comb begin
      if (EDGE_MODE == 0) begin
        tog_d = (state_q == PRESSED) && (state_d == RELEASED);
      end else begin
        tog_d = (state_q == RELEASED) && (state_d == PRESSED);
      end
      hold_d = (state_q == PRESSED) && (state_d == HELD);
      led_d  = led_q;
      if (i_Clear || hold_d) begin
        led_d = 1'b0;
      end else if (tog_d) begin
        led_d = ~led_q;
      end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        db_q       <= 1'b0;
        db_cnt_q   <= '0;
        state_q    <= RELEASED;
        hold_cnt_q <= '0;
        led_q      <= 1'b0;
        tog_q      <= 1'b0;
        hold_q     <= 1'b0;
      end else begin
        db_q       <= db_d;
        db_cnt_q   <= db_cnt_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        led_q      <= led_d;
        tog_q      <= tog_d;
        hold_q     <= hold_d;
      end
    end

    assign o_LED[n]       = led_q;
    assign o_Debounced[n] = db_q;
    assign o_Toggle[n]    = tog_q;
    assign o_Hold[n]      = hold_q;
  end

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Bench for switch_toggle_bank: two instances (release-edge and press-edge
// toggling) share stimulus and are compared each cycle against a timing model.
module tb_switch_toggle_bank;

  localparam int NUM_CH = 4;
  localparam int DEB    = 4;
  localparam int HOLD   = 10;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr   = 1'b0;
  logic [NUM_CH-1:0] sw    = '0;

  logic [NUM_CH-1:0] led[2];
  logic [NUM_CH-1:0] db[2];
  logic [NUM_CH-1:0] tog[2];
  logic [NUM_CH-1:0] hld[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_toggle_bank #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .EDGE_MODE(0)) dut_rel (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw), .i_Clear(clr),
    .o_LED(led[0]), .o_Debounced(db[0]), .o_Toggle(tog[0]), .o_Hold(hld[0])
  );

  switch_toggle_bank #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .EDGE_MODE(1)) dut_prs (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw), .i_Clear(clr),
    .o_LED(led[1]), .o_Debounced(db[1]), .o_Toggle(tog[1]), .o_Hold(hld[1])
  );

  // Reference model: raw sample history plus per-channel press timestamps.
  logic [NUM_CH-1:0] raw_q[$];
  logic [NUM_CH-1:0] m_db;
  logic [NUM_CH-1:0] m_led[2];
  logic [NUM_CH-1:0] m_tog[2];
  logic [NUM_CH-1:0] m_hold[2];
  int                pressed_at[2][NUM_CH];
  bit                held[2][NUM_CH];
  int                t = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    repeat (DEB + 2) raw_q.push_back('0);
    m_db = '0;
    for (int m = 0; m < 2; m++) begin
      m_led[m]  = '0;
      m_tog[m]  = '0;
      m_hold[m] = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pressed_at[m][ch] = -1;
        held[m][ch]       = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    logic [NUM_CH-1:0] new_db;
    logic [NUM_CH-1:0] v;
    t++;
    raw_q.push_front(sw);
    void'(raw_q.pop_back());
    // Debounced level flips once the synchronised level (two samples late)
    // has disagreed with it for DEB consecutive edges.
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit all_diff = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) begin
        v = raw_q[k];
        if (v[ch] == m_db[ch]) all_diff = 1'b0;
      end
      new_db[ch] = all_diff ? ~m_db[ch] : m_db[ch];
    end
    for (int m = 0; m < 2; m++) begin
      m_tog[m]  = '0;
      m_hold[m] = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        bit tg = 1'b0;
        bit hp = 1'b0;
        if (held[m][ch]) begin
          if (!m_db[ch]) held[m][ch] = 1'b0;
        end else if (pressed_at[m][ch] < 0) begin
          if (m_db[ch]) begin
            pressed_at[m][ch] = t;
            tg = (m == 1);
          end
        end else begin
          if (!m_db[ch]) begin
            pressed_at[m][ch] = -1;
            tg = (m == 0);
          end else if (t - pressed_at[m][ch] == HOLD) begin
            pressed_at[m][ch] = -1;
            held[m][ch]       = 1'b1;
            hp = 1'b1;
          end
        end
        m_tog[m][ch]  = tg;
        m_hold[m][ch] = hp;
        if (clr || hp) m_led[m][ch] = 1'b0;
        else if (tg)   m_led[m][ch] = ~m_led[m][ch];
      end
    end
    m_db = new_db;
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("led%0d", m),  32'(led[m]), 32'(m_led[m]));
      check_eq($sformatf("db%0d", m),   32'(db[m]),  32'(m_db));
      check_eq($sformatf("tog%0d", m),  32'(tog[m]), 32'(m_tog[m]));
      check_eq($sformatf("hold%0d", m), 32'(hld[m]), 32'(m_hold[m]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic db_latency(input int ch, input string tag);
    int n = 0;
    while (db[0][ch] !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n - 1), 32'(DEB + 1));
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int remain[NUM_CH];

    model_reset();
    #1 compare_all();
    run(2);
    #2 rst_n = 1'b1;
    run(2);

    // ch0 press then release
    sw[0] = 1'b1;
    db_latency(0, "db_rise_lat");
    run(3);
    sw[0] = 1'b0;
    run(10);

    // ch1 short glitch
    sw[1] = 1'b1;
    run(3);
    sw[1] = 1'b0;
    run(10);
    check_eq("glitch_db1", 32'(db[0][1]), 0);
    check_eq("glitch_led1", 32'(led[0][1]), 0);

    // ch2 toggle on, then long hold clears it
    sw[2] = 1'b1; run(8);
    sw[2] = 1'b0; run(10);
    sw[2] = 1'b1; run(22);
    sw[2] = 1'b0; run(10);
    check_eq("hold_led2", 32'(led[0][2]), 0);

    // ch3 press-edge toggling, then clear coinciding with the second toggle
    sw[3] = 1'b1; run(8);
    sw[3] = 1'b0; run(10);
    check_eq("prs_led3", 32'(led[1][3]), 1);
    sw[3] = 1'b1; run(6);
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("clr_tog3", 32'(tog[1][3]), 1);
    check_eq("clr_led3", 32'(led[1][3]), 0);
    sw[3] = 1'b0; run(10);

    // simultaneous press on ch0 and ch1
    sw[1:0] = 2'b11; run(8);
    sw[1:0] = 2'b00; run(10);

    // reset mid-debounce with ch2 held through release
    sw[2] = 1'b1; run(2);
    async_reset();
    run(3);
    #2 rst_n = 1'b1;
    db_latency(2, "db_rst_lat");
    run(6);
    sw[2] = 1'b0; run(10);

    // randomized phase with bounces, long holds, clears and one reset
    for (int ch = 0; ch < NUM_CH; ch++) remain[ch] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (remain[ch] == 0) begin
          sw[ch] = 1'($urandom_range(0, 1));
          remain[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB))
                                                   : int'($urandom_range(DEB, 3 * HOLD));
        end
        remain[ch]--;
      end
      clr = ($urandom_range(0, 29) == 0);
      if (i == 1500) begin
        async_reset();
        run(2);
        #2 rst_n = 1'b1;
      end
      tick();
    end
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_toggle_bank.md
# switch_toggle_bank

Parametrised bank of NUM_CH push-switch channels. Each channel synchronises, debounces and classifies its switch (press, release, long hold) and drives a toggling LED register. It replaces per-switch hand-written toggle logic at the board top level, between the raw switch pins and the LED pins. It adds debounce, a selectable toggle edge, long-press clear, a global clear, and event pulses for downstream logic.

## Interface
- NUM_CH, 4: number of independent switch/LED channels (≥1).
- DEBOUNCE_CYCLES, 250000: consecutive cycles a synchronised level must differ from the debounced level before it is accepted (≥1; 10 ms at 25 MHz).
- HOLD_CYCLES, 25000000: cycles a debounced press must persist to count as a long hold; 0 disables hold detection.
- EDGE_MODE, 0: 0 = toggle on release, 1 = toggle on press.
- i_Clk  in  1  system clock; all logic is on its rising edge.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Switch  in  NUM_CH  raw switch levels, active high, asynchronous to i_Clk.
- i_Clear  in  1  synchronous clear of all LED registers.
- o_LED  out  NUM_CH  per-channel toggle state.
- o_Debounced  out  NUM_CH  debounced switch level.
- o_Toggle  out  NUM_CH  one-cycle pulse on the cycle o_LED[n] changes due to a toggle.
- o_Hold  out  NUM_CH  one-cycle pulse on entry to HELD.

## Operation
- Reset (i_Rst_L=0, asynchronous): both sync flops, debounced level, both counters, and all outputs go to 0; every FSM goes to RELEASED.
- Per channel:
  - Sync: two flops, sync1 ← i_Switch[n], sync2 ← sync1.
  - Debounce: when sync2 ≠ debounced and count = DEBOUNCE_CYCLES−1, set debounced ← sync2 and count ← 0. When sync2 ≠ debounced otherwise, count increments. When sync2 = debounced, count ← 0.
  - A level that reverts before acceptance is discarded entirely. o_Debounced = debounced level.
- FSM states:
  - RELEASED → PRESSED when debounced=1. Clears the hold counter.
  - PRESSED → RELEASED when debounced=0.
  - PRESSED → HELD when HOLD_CYCLES≠0 and the hold counter = HOLD_CYCLES−1. The hold counter increments each cycle in PRESSED.
  - HELD → RELEASED when debounced=0.
- Toggle events:
  - EDGE_MODE=0: PRESSED→RELEASED only. A release from HELD never toggles.
  - EDGE_MODE=1: RELEASED→PRESSED.
  - On a toggle event: o_LED[n] inverts and o_Toggle[n]=1 for that one cycle.
- HELD entry: o_LED[n] ← 0 and o_Hold[n]=1 for one cycle. o_Toggle[n] is not asserted on HELD entry.
- i_Clear=1: all o_LED ← 0 on that edge.
  - Clear wins over a simultaneous toggle or HELD entry; the pulses still fire.
  - Clear does not affect FSMs, counters or o_Debounced.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No wrap-around is reachable, because counters reset at their terminal value.

## Timing
- Take edge 0 as the first rising edge at which i_Switch[n] is sampled at a new, then-stable level:
  - sync2 holds the new level after edge 1.
  - o_Debounced changes at edge DEBOUNCE_CYCLES+1.
  - FSM, o_LED, o_Toggle and o_Hold respond at edge DEBOUNCE_CYCLES+2.
- Long hold: o_Hold fires HOLD_CYCLES edges after the PRESSED entry edge.
- Pulses last exactly one cycle; there are no back-to-back pulses on a channel without a new debounced transition.
- A switch held high through reset release is seen as a fresh press, with DEBOUNCE_CYCLES+2 edges of latency after reset deassertion.
- Reset asserted mid-operation:
  - All state and outputs go to 0 immediately, independent of i_Clk.
  - Pending debounce and hold counts are lost.

## Test plan
Bench parameters: NUM_CH=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, EDGE_MODE=0 unless stated.
- Reset with i_Switch=4'b0000 → all outputs 0. Press ch0 for 6 cycles, then release → o_Debounced[0] rises at edge 5. o_LED[0] flips 0→1 with an o_Toggle[0] pulse 6 edges after release sampling.
- Glitch on ch1 high for 3 cycles (< DEBOUNCE_CYCLES) → o_Debounced[1], o_LED[1] and o_Toggle[1] stay 0.
- ch2: toggle to 1, then press for 20 cycles → o_Hold[2] pulses 10 edges after PRESSED entry. o_LED[2] → 0. The release produces no toggle, so o_LED[2] stays 0.
- EDGE_MODE=1, press ch3 → o_LED[3] goes to 1 at edge 6 after the press, and the release does not toggle it back. Assert i_Clear on the same cycle as a second-press toggle → o_LED[3]=0 and o_Toggle[3] pulses.
- Press ch0 and ch1 in the same cycle → both toggle on the same edge. Assert i_Rst_L=0 mid-debounce on ch2 → all outputs 0 asynchronously. After release of reset, with ch2 still high → press accepted at edge DEBOUNCE_CYCLES+1.
